// File: rtl/hex_entry.sv
// Hex keypad entry: debounced buttons build a 4-nibble value and submit it with a valid/ready handshake.
// Define HEX_ENTRY_BCD_EN to reject nibbles above 9 and flag them on digitErr.
module hex_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        btnDigit,
  input  logic        btnClear,
  input  logic        btnSubmit,
  output logic [15:0] outputVal,
  output logic [15:0] entryVal,
  output logic        entryValid,
  input  logic        entryReady,
  output logic [2:0]  digitCount,
  output logic        digitErr
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef HEX_ENTRY_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  typedef enum logic {ENTER, HOLD} state_e;

  // Button index: 0 = digit, 1 = clear, 2 = submit.
  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync2_q, db_q, db_prev_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [3:0]       sw_q;
  logic [2:0]       press;

  assign btn_raw = {btnSubmit, btnClear, btnDigit};
  assign press   = db_q & ~db_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      sw_q      <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      sw_q      <= sw;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e      state_q, state_d;
  logic [15:0] val_q, val_d;
  logic [15:0] entry_q, entry_d;
  logic        valid_q, valid_d;
  logic [2:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        bad_digit;

  assign bad_digit = BCD_EN && (sw_q > 4'd9);

  // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    entry_d = entry_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      ENTER: begin
        if (press[1]) begin
          val_d   = '0;
          count_d = '0;
        end else if (press[2]) begin
          if (count_q != 3'd0) begin
            entry_d = val_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (press[0]) begin
          if (bad_digit) begin
            err_d = 1'b1;
          end else begin
            val_d   = {val_q[11:0], sw_q};
            count_d = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          end
        end
      end
      HOLD: begin
        if (entryReady) begin
          valid_d = 1'b0;
          val_d   = '0;
          count_d = '0;
          state_d = ENTER;
        end
      end
      default: state_d = ENTER;
    endcase
  end

  // NOTE: only control/data registers are reset here; there is no memory array needing a reset loop.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= ENTER;
      val_q   <= '0;
      entry_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      entry_q <= entry_d;
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign outputVal  = val_q;
  assign entryVal   = entry_q;
  assign entryValid = valid_q;
  assign digitCount = count_q;
  assign digitErr   = err_q;

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: directed scenarios plus random button sequences against a nibble-queue model.
module tb_hex_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sw;
  logic        btnDigit, btnClear, btnSubmit, entryReady;
  logic [15:0] outputVal, entryVal;
  logic        entryValid, digitErr;
  logic [2:0]  digitCount;

  hex_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .sw        (sw),
    .btnDigit  (btnDigit),
    .btnClear  (btnClear),
    .btnSubmit (btnSubmit),
    .outputVal (outputVal),
    .entryVal  (entryVal),
    .entryValid(entryValid),
    .entryReady(entryReady),
    .digitCount(digitCount),
    .digitErr  (digitErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_total = 0;

  always @(negedge clk) if (digitErr === 1'b1) err_total++;

  // Reference model: the entry is the list of nibbles typed, newest last, at most four kept.
  logic [3:0]  m_digits[$];
  logic        m_valid = 1'b0;
  logic [15:0] m_entry = '0;
  int          m_err = 0;

  function automatic logic [15:0] m_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + int'(m_digits[i]);
    return 16'(v);
  endfunction

  function automatic bit nib_rejected(input logic [3:0] nib);
`ifdef HEX_ENTRY_BCD_EN
    return nib > 4'd9;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".outputVal"},  outputVal,  m_value());
    check({tag, ".digitCount"}, 16'(digitCount), 16'(m_digits.size()));
    check({tag, ".entryValid"}, 16'(entryValid), 16'(m_valid));
    if (m_valid) check({tag, ".entryVal"}, entryVal, m_entry);
    check({tag, ".digitErr"},   16'(err_total), 16'(m_err));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bit 0 = digit, 1 = clear, 2 = submit; buttons held 10 cycles, then released long enough to settle.
  task automatic press(input logic [2:0] mask, input logic [3:0] nib);
    sw = nib;
    tick(2);
    {btnSubmit, btnClear, btnDigit} = mask;
    tick(10);
    {btnSubmit, btnClear, btnDigit} = 3'b000;
    tick(12);
    if (!m_valid) begin
      if (mask[1]) begin
        m_digits.delete();
      end else if (mask[2]) begin
        if (m_digits.size() > 0) begin
          m_entry = m_value();
          m_valid = 1'b1;
        end
      end else if (mask[0]) begin
        if (nib_rejected(nib)) begin
          m_err++;
        end else begin
          m_digits.push_back(nib);
          if (m_digits.size() > 4) void'(m_digits.pop_front());
        end
      end
    end
  endtask

  task automatic glitch();
    btnDigit = 1'b1;
    tick(3);
    btnDigit = 1'b0;
    tick(12);
  endtask

  task automatic ready_pulse();
    entryReady = 1'b1;
    tick(2);
    entryReady = 1'b0;
    tick(1);
    if (m_valid) begin
      m_valid = 1'b0;
      m_digits.delete();
    end
  endtask

  initial begin
    logic hold_ok;
    int   r;
    reset = 1'b1; sw = '0; entryReady = 1'b0;
    btnDigit = 1'b0; btnClear = 1'b0; btnSubmit = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset.entryVal", entryVal, 16'h0000);
    check_all("reset");

    for (int d = 1; d <= 4; d++) press(3'b001, 4'(d));
    check("four_digits.value", outputVal, 16'h1234);
    check_all("four_digits");

    press(3'b001, 4'h5);
    check("saturate.value", outputVal, 16'h2345);
    check_all("saturate");
    glitch();
    check_all("glitch");

    press(3'b100, 4'h0);
    check("submit.entryVal", entryVal, 16'h2345);
    hold_ok = 1'b1;
    sw = 4'h6;
    for (int c = 0; c < 24; c++) begin
      btnDigit = (c >= 2 && c < 14);
      btnClear = (c >= 2 && c < 14);
      @(negedge clk);
      if (!(entryValid === 1'b1 && entryVal === 16'h2345 && outputVal === 16'h2345)) hold_ok = 1'b0;
    end
    btnDigit = 1'b0; btnClear = 1'b0;
    tick(4);
    check("hold.stable", 16'(hold_ok), 16'h1);
    check_all("hold");
    entryReady = 1'b1;
    tick(1);
    entryReady = 1'b0;
    m_valid = 1'b0;
    m_digits.delete();
    check("ack.entryValid", 16'(entryValid), 16'h0);
    check_all("ack");

    press(3'b001, 4'hA);
    press(3'b001, 4'hB);
    check("ab.value", outputVal, 16'h00AB);
    press(3'b110, 4'h0);
    check_all("clear_submit");
    press(3'b100, 4'h0);
    check_all("submit_empty");

    press(3'b001, 4'hC);
    check_all("nibble_c");

    press(3'b001, 4'h9);
    press(3'b100, 4'h0);
    check_all("pre_reset_hold");
    reset = 1'b1;
    tick(1);
    m_valid = 1'b0; m_entry = '0; m_digits.delete();
    check("reset_hold.entryVal", entryVal, 16'h0000);
    check_all("reset_hold");
    sw = 4'h7;
    btnDigit = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(15);
    btnDigit = 1'b0;
    tick(12);
    m_digits.push_back(4'h7);
    check_all("held_through_reset");

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      press(3'b001, 4'($urandom_range(0, 15)));
      else if (r == 5) press(3'b010, 4'h0);
      else if (r == 6) press(3'b100, 4'h0);
      else if (r == 7) press(3'b110, 4'h0);
      else if (r == 8) ready_pulse();
      else             glitch();
      check_all($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
